// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state type, the index-width helper and the
// round-robin pick function used by the priority picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Widest requester count the picker is built for
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Index width for n requesters; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid scanning ptr, ptr+1, ... modulo n.
  // Scanning from the far end down lets the nearest candidate win.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[3'(j)]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshake and FIFO write-port signals.
// The master side is the arbiter (it owns the FIFO write port);
// the slave side is the producers plus the FIFO status.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int IW = fifo_arb_pkg::idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_overflow;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic                          err_overflow;

  modport master (
    input  req_valid, req_data, req_last,
    input  fifo_full, fifo_almostfull, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in,
    output grant_id, busy, err_overflow
  );

  modport slave (
    output req_valid, req_data, req_last,
    output fifo_full, fifo_almostfull, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in,
    input  grant_id, busy, err_overflow
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: rotates the valid vector by ptr
// and priority-encodes, returning the chosen index and a found flag.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  // Widen to the picker's native size and run the rotate-and-encode
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    pick                     = rr_pick(valid_ext, 3'(ptr), NUM_REQ);
    idx                      = IW'(pick.idx);
    found                    = pick.found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ
// producers, granting bursts of up to MAX_BURST beats.
// Optional feature macro: FWA_GRANT_STATS_EN adds per-requester
// saturating accepted-beat counters (grant_cnt) with a clear (stats_clr).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FWA_GRANT_STATS_EN
  input  logic                   stats_clr,
  output logic [NUM_REQ*16-1:0]  grant_cnt,
`endif
  fifo_wr_arbiter_if.master      bus
);

  localparam int            IW        = idx_w(NUM_REQ);
  localparam int            BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_e            state;
  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         next_ptr;
  logic [BW-1:0]         beat_cnt;
  logic                  pick_found;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept;
  logic                  burst_end;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Route the current grantee's valid, last and data lines
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake and FIFO write path; a full FIFO stalls but never ends a burst
  always_comb begin
    accept        = (state == BURST) && g_valid && !bus.fifo_full;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == BURST) && !bus.fifo_full && (grant_q == IW'(i)))
        bus.req_ready[i] = 1'b1;
    end
    bus.fifo_wr_en   = accept;
    bus.fifo_data_in = (state == BURST) ? g_data : '0;
    burst_end        = !g_valid ||
                       (accept && (g_last || (beat_cnt == LAST_BEAT) || bus.fifo_almostfull));
    next_ptr         = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
  end

  assign bus.busy     = (state == BURST);
  assign bus.grant_id = grant_q;

  // Arbitration FSM: pick a grantee in IDLE, stream its beats in BURST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept)
            beat_cnt <= beat_cnt + BW'(1);
          if (burst_end) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag, only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.err_overflow <= 1'b0;
    else if (bus.fifo_overflow)
      bus.err_overflow <= 1'b1;
  end

`ifdef FWA_GRANT_STATS_EN
  // Per-requester saturating count of accepted beats; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((grant_q == IW'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a queue-based producer and
// arbitration model predicts every cycle's busy/ready/grant and the
// order of FIFO writes; an independent monitor compares at negedge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 8;
  localparam int IW = idx_w(N);

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic busy; logic [N-1:0] ready; logic [IW-1:0] grant; } cyc_t;
  typedef struct { logic [DW-1:0] data; logic [IW-1:0] owner; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

`ifdef FWA_GRANT_STATS_EN
  logic            stats_clr = 1'b0;
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FWA_GRANT_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  beat_t prod_q[N][$];
  cyc_t  cyc_q[$];
  wr_t   wr_q[$];

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int seq      = 0;
  int stat_model[N];

  bit full_force, af_force;
  int full_pct, af_pct, wd_pct, af_at_beat;

  bit m_busy;
  int m_owner, m_count, m_ptr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_burst(input int r, input int len, input bit last_at_end);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(r * 4096 + (seq % 4096));
      b.last = last_at_end && (k == len - 1);
      seq++;
      prod_q[r].push_back(b);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += prod_q[i].size();
    return s;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_count = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      prod_q[i].delete();
      stat_model[i] = 0;
    end
    cyc_q.delete();
    wr_q.delete();
  endtask

  // Drive one cycle of producer/FIFO inputs and advance the reference model
  task automatic apply_stimulus();
    logic  full_now, af_now;
    cyc_t  e;
    wr_t   w;
    beat_t b;
    bit    hold;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      hold = (wd_pct > 0) && (int'($urandom_range(0, 99)) < wd_pct);
      if (prod_q[i].size() > 0 && !hold) begin
        bus.req_valid[i]           = 1'b1;
        bus.req_last[i]            = prod_q[i][0].last;
        bus.req_data[i*DW +: DW]   = prod_q[i][0].data;
      end else begin
        bus.req_valid[i]           = 1'b0;
        bus.req_last[i]            = 1'($urandom_range(0, 1));
        bus.req_data[i*DW +: DW]   = DW'($urandom);
      end
    end
    full_now = full_force || ((full_pct > 0) && (int'($urandom_range(0, 99)) < full_pct));
    af_now   = af_force || ((af_pct > 0) && (int'($urandom_range(0, 99)) < af_pct)) ||
               ((af_at_beat >= 0) && m_busy && (m_count == af_at_beat));
    bus.fifo_full       = full_now;
    bus.fifo_almostfull = af_now;

    e.busy  = m_busy;
    e.grant = IW'(m_owner);
    e.ready = (m_busy && !full_now) ? (N'(1) << m_owner) : '0;
    cyc_q.push_back(e);

    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && bus.req_valid[(m_ptr + k) % N]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_count = 0;
        end
      end
    end else if (!bus.req_valid[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else if (!full_now) begin
      b       = prod_q[m_owner].pop_front();
      w.data  = b.data;
      w.owner = IW'(m_owner);
      wr_q.push_back(w);
      m_count++;
      if (stat_model[m_owner] < 65535) stat_model[m_owner]++;
      if (b.last || m_count == MB || af_now) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while (pending() > 0 && c < max_cycles) begin
      apply_stimulus();
      c++;
    end
    check_output("drain_done", pending(), 0);
    run_cycles(3);
    @(negedge clk);
    #1;
    check_output("wr_q_empty", wr_q.size(), 0);
  endtask

  // Monitor: pop the per-cycle expectation and the write scoreboard
  cyc_t mon_e;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        check_output("busy", bus.busy, mon_e.busy);
        check_output("req_ready", bus.req_ready, mon_e.ready);
        if (mon_e.busy) check_output("grant_id", bus.grant_id, mon_e.grant);
        else            check_output("idle_data", bus.fifo_data_in, 0);
      end
      if (bus.fifo_wr_en) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          check_output("spurious_wr", bus.fifo_wr_en, 0);
        end else begin
          mon_w = wr_q.pop_front();
          check_output("wr_data", bus.fifo_data_in, mon_w.data);
          check_output("wr_grant", bus.grant_id, mon_w.owner);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_start;
    bus.req_valid       = '0;
    bus.req_data        = '0;
    bus.req_last        = '0;
    bus.fifo_full       = 1'b0;
    bus.fifo_almostfull = 1'b0;
    bus.fifo_overflow   = 1'b0;
    full_force = 0; af_force = 0;
    full_pct = 0; af_pct = 0; wd_pct = 0; af_at_beat = -1;
    model_reset();

    #12;
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_ready", bus.req_ready, 0);
    check_output("rst_wr_en", bus.fifo_wr_en, 0);
    check_output("rst_data", bus.fifo_data_in, 0);
    check_output("rst_grant", bus.grant_id, 0);
    check_output("rst_err", bus.err_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    $display("[TB] four requesters, three beats each");
    for (int r = 0; r < N; r++) load_burst(r, 3, 1'b1);
    wr_start = wr_seen;
    drain(200);
    check_output("p1_write_count", wr_seen - wr_start, 12);

    $display("[TB] long stream against a short-burst neighbour");
    load_burst(2, 20, 1'b0);
    for (int k = 0; k < 3; k++) load_burst(3, 2, 1'b1);
    drain(300);

    $display("[TB] full FIFO stalls a burst");
    load_burst(0, 10, 1'b1);
    run_cycles(3);
    full_force = 1;
    run_cycles(5);
    full_force = 0;
    drain(200);

    $display("[TB] almost-full ends a burst early");
    load_burst(1, 6, 1'b1);
    af_at_beat = 1;
    run_cycles(4);
    af_at_beat = -1;
    drain(200);

    $display("[TB] randomized traffic");
    full_pct = 20; af_pct = 10; wd_pct = 15;
    for (int t = 0; t < 30; t++) begin
      load_burst($urandom_range(0, N - 1), $urandom_range(1, 12), ($urandom_range(0, 9) < 7));
      run_cycles($urandom_range(5, 30));
    end
    full_pct = 0; af_pct = 0; wd_pct = 0;
    drain(2000);

`ifdef FWA_GRANT_STATS_EN
    for (int i = 0; i < N; i++) check_output("grant_cnt", grant_cnt[i*16 +: 16], stat_model[i]);
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      stat_model[i] = 0;
      check_output("grant_cnt_clr", grant_cnt[i*16 +: 16], 0);
    end
`endif

    $display("[TB] reset in the middle of a burst");
    load_burst(2, 8, 1'b1);
    load_burst(3, 8, 1'b1);
    for (int c = 0; c < 40 && !(m_busy && m_count == 4); c++) apply_stimulus();
    @(negedge clk);
    #2;
    check_output("pre_rst_busy", bus.busy, m_busy);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy", bus.busy, 0);
    check_output("mid_rst_ready", bus.req_ready, 0);
    check_output("mid_rst_wr_en", bus.fifo_wr_en, 0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int r = N - 1; r >= 0; r--) load_burst(r, 2, 1'b1);
    drain(200);

`ifdef FWA_GRANT_STATS_EN
    for (int i = 0; i < N; i++) check_output("grant_cnt_post", grant_cnt[i*16 +: 16], stat_model[i]);
`endif

    $display("[TB] sticky overflow flag");
    check_output("err_before", bus.err_overflow, 0);
    @(posedge clk); #1 bus.fifo_overflow = 1'b1;
    @(posedge clk); #1 bus.fifo_overflow = 1'b0;
    check_output("err_set", bus.err_overflow, 1);
    repeat (5) @(posedge clk);
    #1;
    check_output("err_sticky", bus.err_overflow, 1);
    rst = 1'b1;
    #1;
    check_output("err_cleared", bus.err_overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
